phy_tx_serializer: RTL and testbench

PHY_TX_SERIALIZER -- requirements
Module: phy_tx_serializer

---
 rtl/phy_tx_serializer_pkg.sv | 14 +
 rtl/phy_tx_serializer_shift_reg.sv | 31 +++
 rtl/phy_tx_serializer.sv | 129 ++++++++++++
 tb/tb_phy_tx_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_serializer_pkg.sv
// Shared constants and state encoding for the PHY transmit serializer and its
// matching receiver.
package phy_tx_serializer_pkg;

    localparam logic [7:0]  COMMA_BYTE   = 8'hBC;
    localparam int unsigned N_SYNC_BYTES = 4;
    localparam int unsigned N_LANES      = 4;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_e;

endpackage

// File: rtl/phy_tx_serializer_shift_reg.sv
// 8-bit parallel-load shift register, MSB first, synchronous active-low reset.
module tx_shift_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       msb
);

    logic [7:0] sr_q;
    logic [7:0] sr_d;

    always_comb begin
        sr_d = load ? din : {sr_q[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!reset_n_sampled()) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    function automatic logic reset_n_sampled();
        return rst_n;
    endfunction

    assign msb = sr_q[7];

endmodule

// File: rtl/phy_tx_serializer.sv
// Four-lane byte serializer: sends N_SYNC commas after reset, then round-robins
// one byte slot per lane, substituting COMMA for any lane that has nothing ready.
module phy_tx_serializer
    import phy_tx_serializer_pkg::*;
#(
    parameter logic [7:0]  COMMA  = COMMA_BYTE,
    parameter int unsigned N_SYNC = N_SYNC_BYTES
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    output logic       data_out,
    output logic       active,
    output logic       byte_start
);

    localparam int unsigned SW = (N_SYNC < 1) ? 1 : $clog2(N_SYNC + 1);
    localparam int unsigned LW = $clog2(N_LANES);

    tx_state_e            state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [SW-1:0]        sync_cnt_q, sync_cnt_d;
    logic                 first_q, first_d;
    logic [N_LANES-1:0]   ready_q, ready_d;
    logic                 byte_start_q, byte_start_d;

    logic                 load;
    logic                 serve;
    logic [7:0]           load_byte;
    logic [7:0]           lane_data;
    logic                 lane_valid;

    always_comb begin
        lane_data  = in0;
        lane_valid = valid_in0;
        case (lane_q)
            2'd0: begin lane_data = in0; lane_valid = valid_in0; end
            2'd1: begin lane_data = in1; lane_valid = valid_in1; end
            2'd2: begin lane_data = in2; lane_valid = valid_in2; end
            2'd3: begin lane_data = in3; lane_valid = valid_in3; end
            default: begin lane_data = in0; lane_valid = valid_in0; end
        endcase
    end

    // The first edge out of reset loads immediately; afterwards a byte is
    // loaded every eighth edge, so the bit counter always reads 0 after a load.
    always_comb begin
        load         = first_q || (bit_cnt_q == 3'd7);
        state_d      = state_q;
        bit_cnt_d    = load ? 3'd0 : bit_cnt_q + 3'd1;
        lane_d       = lane_q;
        sync_cnt_d   = sync_cnt_q;
        first_d      = 1'b0;
        ready_d      = '0;
        byte_start_d = load;
        load_byte    = COMMA;
        serve        = 1'b0;

        if (load) begin
            if (state_q == ST_SYNC) begin
                if (sync_cnt_q == SW'(N_SYNC)) begin
                    state_d = ST_ACTIVE;
                    serve   = 1'b1;
                end else begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                end
            end else begin
                serve = 1'b1;
            end
        end

        // An empty lane still consumes its slot; the pointer always advances.
        if (serve) begin
            lane_d = lane_q + 1'b1;
            if (lane_valid) begin
                load_byte       = lane_data;
                ready_d[lane_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q      <= ST_SYNC;
            bit_cnt_q    <= '0;
            lane_q       <= '0;
            sync_cnt_q   <= '0;
            first_q      <= 1'b1;
            ready_q      <= '0;
            byte_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            lane_q       <= lane_d;
            sync_cnt_q   <= sync_cnt_d;
            first_q      <= first_d;
            ready_q      <= ready_d;
            byte_start_q <= byte_start_d;
        end
    end

    tx_shift_reg u_shift (
        .clk   (clk_32f),
        .rst_n (reset),
        .load  (load),
        .din   (load_byte),
        .msb   (data_out)
    );

    assign ready0     = ready_q[0];
    assign ready1     = ready_q[1];
    assign ready2     = ready_q[2];
    assign ready3     = ready_q[3];
    assign active     = (state_q == ST_ACTIVE);
    assign byte_start = byte_start_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer: slot-arithmetic reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_phy_tx_serializer;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         NSYNC = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] din [4];
    logic [3:0] vld;
    logic       r0, r1, r2, r3;
    logic       data_out, active, byte_start;
    logic [3:0] rdy;

    always #5 clk_32f = ~clk_32f;
    assign rdy = {r3, r2, r1, r0};

    phy_tx_serializer #(.COMMA(8'hBC), .N_SYNC(4)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .in0        (din[0]),
        .in1        (din[1]),
        .in2        (din[2]),
        .in3        (din[3]),
        .valid_in0  (vld[0]),
        .valid_in1  (vld[1]),
        .valid_in2  (vld[2]),
        .valid_in3  (vld[3]),
        .ready0     (r0),
        .ready1     (r1),
        .ready2     (r2),
        .ready3     (r3),
        .data_out   (data_out),
        .active     (active),
        .byte_start (byte_start)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    always @(posedge clk_32f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: edge k after release is slot (k-1)/8, bit (k-1)%8.
    int         k      = 0;
    logic [7:0] cur    = 8'h00;
    logic       m_do   = 1'b0;
    logic       m_act  = 1'b0;
    logic       m_bs   = 1'b0;
    logic [3:0] m_rdy  = 4'h0;
    bit         mvalid = 1'b0;

    always @(posedge clk_32f) begin
        int ph, slot, ln;
        if (!reset) begin
            k = 0; cur = 8'h00; m_do = 1'b0; m_act = 1'b0; m_bs = 1'b0; m_rdy = 4'h0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            k++;
            ph    = (k - 1) % 8;
            slot  = (k - 1) / 8;
            m_rdy = 4'h0;
            if (ph == 0) begin
                if (slot < NSYNC) begin
                    cur = COMMA;
                end else begin
                    ln = (slot - NSYNC) % 4;
                    if (vld[ln]) begin
                        cur       = din[ln];
                        m_rdy[ln] = 1'b1;
                    end else begin
                        cur = COMMA;
                    end
                end
            end
            m_do  = cur[7 - ph];
            m_bs  = (ph == 0);
            m_act = (slot >= NSYNC);
        end
        #1;
        if (mvalid) begin
            check($sformatf("cycle%0d_outputs", cyc),
                  {25'd0, data_out, active, byte_start, rdy},
                  {25'd0, m_do, m_act, m_bs, m_rdy});
            check($sformatf("cycle%0d_ready_onehot", cyc), {31'd0, ($countones(rdy) <= 1)}, 32'd1);
        end
    end

    // Byte and ready-pulse logger used by the directed scenarios.
    logic [7:0] q_bytes [$];
    int         rq0 [$], rq1 [$], rq2 [$], rq3 [$];
    logic [7:0] sh = 8'h00;
    int         nb = 0;

    always @(posedge clk_32f) begin
        #1;
        if (!reset) begin
            nb = 0;
        end else begin
            if (byte_start) begin
                sh = {7'd0, data_out};
                nb = 1;
            end else if (nb > 0) begin
                sh = {sh[6:0], data_out};
                nb++;
            end
            if (nb == 8) begin
                q_bytes.push_back(sh);
                nb = 0;
            end
            if (r0) rq0.push_back(cyc);
            if (r1) rq1.push_back(cyc);
            if (r2) rq2.push_back(cyc);
            if (r3) rq3.push_back(cyc);
        end
    end

    function automatic logic [31:0] qb(input int j);
        return (j < q_bytes.size()) ? {24'd0, q_bytes[j]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int rqv(input int lane, input int idx);
        case (lane)
            0: return (idx < rq0.size()) ? rq0[idx] : -100000;
            1: return (idx < rq1.size()) ? rq1[idx] : -100000;
            2: return (idx < rq2.size()) ? rq2[idx] : -100000;
            default: return (idx < rq3.size()) ? rq3[idx] : -100000;
        endcase
    endfunction

    task automatic clear_logs();
        q_bytes.delete(); rq0.delete(); rq1.delete(); rq2.delete(); rq3.delete();
    endtask

    task automatic tick();
        @(posedge clk_32f);
        #2;
    endtask

    task automatic reset_release(output int rel);
        reset = 1'b0;
        repeat (3) tick();
        check("reset_state", {26'd0, data_out, active, byte_start, rdy}, 32'd0);
        reset = 1'b1;
        rel   = cyc;
        clear_logs();
    endtask

    task automatic wait_active(input int rel, input string name);
        int n = 0;
        while (!active && n < 100) begin
            tick();
            n++;
        end
        check(name, cyc - rel, 33);
    endtask

    initial begin
        int rel;
        logic [7:0] pat [4];
        logic [7:0] pat3 [4];
        reset = 1'b0;
        vld   = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;

        // Idle link: commas only, active after 33 edges.
        reset_release(rel);
        wait_active(rel, "s1_active_rise");
        repeat (24) tick();
        for (int j = 0; j < 6; j++) check($sformatf("s1_byte%0d", j), qb(j), 32'h0000_00BC);

        // All lanes valid.
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        vld = 4'hF;
        reset_release(rel);
        wait_active(rel, "s2_active_rise");
        repeat (70) tick();
        for (int j = 4; j < 12; j++) check($sformatf("s2_byte%0d", j), qb(j), {24'd0, pat[(j - 4) % 4]});
        check("s2_ready0_first", rqv(0, 0) - rel, 33);
        check("s2_ready1_gap", rqv(1, 0) - rqv(0, 0), 8);
        check("s2_ready2_gap", rqv(2, 0) - rqv(1, 0), 8);
        check("s2_ready3_gap", rqv(3, 0) - rqv(2, 0), 8);
        check("s2_ready0_period", rqv(0, 1) - rqv(0, 0), 32);

        // Only lane 2 valid.
        din[0] = 8'h5A; din[1] = 8'h5A; din[2] = 8'hA5; din[3] = 8'h5A;
        pat3[0] = 8'hBC; pat3[1] = 8'hBC; pat3[2] = 8'hA5; pat3[3] = 8'hBC;
        vld = 4'b0100;
        reset_release(rel);
        wait_active(rel, "s3_active_rise");
        repeat (70) tick();
        for (int j = 4; j < 12; j++) check($sformatf("s3_byte%0d", j), qb(j), {24'd0, pat3[(j - 4) % 4]});
        check("s3_other_readies", rq0.size() + rq1.size() + rq3.size(), 0);
        check("s3_ready2_count", rq2.size(), 2);
        check("s3_ready2_first", rqv(2, 0) - rel, 49);

        // Lane data equal to COMMA goes out unescaped and is acknowledged.
        din[0] = 8'h77; din[1] = 8'hBC; din[2] = 8'h77; din[3] = 8'h77;
        vld = 4'b0010;
        reset_release(rel);
        wait_active(rel, "s4_active_rise");
        repeat (70) tick();
        for (int j = 4; j < 8; j++) check($sformatf("s4_byte%0d", j), qb(j), 32'h0000_00BC);
        check("s4_ready1_first", rqv(1, 0) - rel, 41);
        check("s4_ready1_count", rq1.size(), 2);

        // Reset in the middle of a data byte.
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        vld = 4'hF;
        reset_release(rel);
        wait_active(rel, "s5_active_rise");
        repeat (3) tick();
        check("s5_bit4_of_0x11", {31'd0, data_out}, 32'd1);
        reset = 1'b0;
        tick();
        check("s5_reset_edge", {27'd0, data_out, rdy}, 32'd0);
        tick();
        reset = 1'b1;
        rel   = cyc;
        clear_logs();
        wait_active(rel, "s5_resync_active_rise");
        for (int j = 0; j < 4; j++) check($sformatf("s5_resync_byte%0d", j), qb(j), 32'h0000_00BC);
        check("s5_no_early_ready", rq1.size() + rq2.size() + rq3.size(), 0);
        check("s5_ready0_after_resync", rqv(0, 0) - rel, 33);

        // Random traffic with upstream hold-until-accepted behaviour and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                reset = 1'b1;
            end
            for (int l = 0; l < 4; l++) begin
                if (!vld[l] || rdy[l]) begin
                    vld[l] = ($urandom_range(0, 2) != 0);
                    din[l] = ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom);
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
